// File: rtl/md_iter_ctrl_if.sv
// Handshake bundle between the MD iteration controller and the RL / motion-update engines.
// The slave modport is the controller's view; the master modport is the sequencer/bench view.
interface md_iter_ctrl_if #(
  parameter int NUM_CELLS  = 64,
  parameter int ITER_WIDTH = 16
);
  logic                  start;
  logic                  abort;
  logic [ITER_WIDTH-1:0] num_iter;
  logic [NUM_CELLS-1:0]  reading_done;
  logic [NUM_CELLS-1:0]  back_pressure;
  logic [NUM_CELLS-1:0]  filter_buffer_empty;
  logic [NUM_CELLS-1:0]  force_valid;
  logic                  mu_done;
  logic                  rl_start;
  logic                  mu_start;
  logic                  busy;
  logic                  done;
  logic [ITER_WIDTH-1:0] iter_cnt;
  logic [31:0]           stall_cnt;
  logic                  timeout_err;

  modport slave (
    input  start, abort, num_iter, reading_done, back_pressure,
           filter_buffer_empty, force_valid, mu_done,
    output rl_start, mu_start, busy, done, iter_cnt, stall_cnt, timeout_err
  );

  modport master (
    output start, abort, num_iter, reading_done, back_pressure,
           filter_buffer_empty, force_valid, mu_done,
    input  rl_start, mu_start, busy, done, iter_cnt, stall_cnt, timeout_err
  );
endinterface

// File: rtl/md_iter_ctrl.sv
// Sequences MD time steps: launch the range-limited array, wait for it to drain, run the
// motion update, repeat num_iter times. Watchdog traps hangs; abort returns to IDLE at once.
module md_iter_ctrl #(
  parameter int NUM_CELLS  = 64,
  parameter int ITER_WIDTH = 16,
  parameter int DRAIN_WAIT = 8,
  parameter int WDOG_WIDTH = 20
) (
  input logic           clk,
  input logic           rst,
  md_iter_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RL_LAUNCH, RL_READ, RL_DRAIN, MU_LAUNCH, MU_WAIT, FINISH, ERR
  } state_e;

  localparam logic [NUM_CELLS-1:0]  CELLS_ALL    = '1;
  localparam logic [7:0]            DRAIN_TARGET = 8'(DRAIN_WAIT);
  localparam logic [WDOG_WIDTH-1:0] WDOG_MAX     = '1;

  state_e                state_q, state_d;
  logic [ITER_WIDTH-1:0] num_iter_q, num_iter_d;
  logic [ITER_WIDTH-1:0] iter_cnt_q, iter_cnt_d;
  logic [31:0]           stall_cnt_q, stall_cnt_d;
  logic [7:0]            drain_cnt_q, drain_cnt_d;
  logic [WDOG_WIDTH-1:0] wdog_q, wdog_d, wdog_inc;
  logic                  timeout_err_q, timeout_err_d;
  logic                  rl_start_q, rl_start_d;
  logic                  mu_start_q, mu_start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic all_read, quiet, any_bp, wdog_run;

  assign all_read = (bus.reading_done == CELLS_ALL);
  assign any_bp   = |bus.back_pressure;
  assign quiet    = (bus.filter_buffer_empty == CELLS_ALL) && !any_bp && !(|bus.force_valid);
  assign wdog_run = (state_q == RL_READ) || (state_q == RL_DRAIN) || (state_q == MU_WAIT);
  assign wdog_inc = wdog_q + WDOG_WIDTH'(1);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    num_iter_d    = num_iter_q;
    iter_cnt_d    = iter_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    timeout_err_d = timeout_err_q;
    drain_cnt_d   = '0;
    wdog_d        = wdog_run ? wdog_inc : wdog_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          num_iter_d    = bus.num_iter;
          iter_cnt_d    = '0;
          stall_cnt_d   = '0;
          timeout_err_d = 1'b0;
          state_d       = (bus.num_iter == '0) ? FINISH : RL_LAUNCH;
        end
      end
      RL_LAUNCH: state_d = RL_READ;
      RL_READ:   if (all_read) state_d = RL_DRAIN;
      RL_DRAIN: begin
        drain_cnt_d = quiet ? drain_cnt_q + 8'd1 : 8'd0;
        if (drain_cnt_d == DRAIN_TARGET) state_d = MU_LAUNCH;
      end
      MU_LAUNCH: state_d = MU_WAIT;
      MU_WAIT: begin
        if (bus.mu_done) begin
          iter_cnt_d = iter_cnt_q + ITER_WIDTH'(1);
          state_d    = (iter_cnt_d == num_iter_q) ? FINISH : RL_LAUNCH;
        end
      end
      FINISH:  state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase

    // Watchdog only fires on a cycle that made no progress out of the waiting state.
    if (wdog_run && state_d == state_q && wdog_inc == WDOG_MAX) begin
      state_d       = ERR;
      timeout_err_d = 1'b1;
    end

    if (state_q != IDLE && state_q != FINISH && state_q != ERR && any_bp &&
        stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Abort wins over everything, including an iteration completing in the same cycle.
    if (bus.abort && state_q != IDLE) begin
      state_d       = IDLE;
      iter_cnt_d    = iter_cnt_q;
      timeout_err_d = timeout_err_q;
    end

    if (state_d != state_q) begin
      wdog_d      = '0;
      drain_cnt_d = '0;
    end

    rl_start_d = (state_d == RL_LAUNCH);
    mu_start_d = (state_d == MU_LAUNCH);
    done_d     = (state_d == FINISH);
    busy_d     = (state_d != IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      num_iter_q    <= '0;
      iter_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      drain_cnt_q   <= '0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
      rl_start_q    <= 1'b0;
      mu_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_iter_q    <= num_iter_d;
      iter_cnt_q    <= iter_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
      rl_start_q    <= rl_start_d;
      mu_start_q    <= mu_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.rl_start    = rl_start_q;
  assign bus.mu_start    = mu_start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.iter_cnt    = iter_cnt_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_md_iter_ctrl.sv
// Directed bench for md_iter_ctrl: the driver pushes expected pulses (kind, latency, counters)
// into a scoreboard queue; a negedge monitor pops and compares each pulse the DUT emits.
module tb_md_iter_ctrl;

  typedef enum logic [1:0] {EV_RL, EV_MU, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       lat;
    int       iter;
    int       stall;
    int       terr;
  } ev_t;

  localparam logic [63:0] BP3 = 64'h8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   last_evt_cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  ev_t  mon_e;
  ev_kind_e mon_kind;
  int   mon_ref;

  md_iter_ctrl_if #(.NUM_CELLS(64), .ITER_WIDTH(16)) bus ();

  md_iter_ctrl #(
    .NUM_CELLS(64), .ITER_WIDTH(16), .DRAIN_WAIT(8), .WDOG_WIDTH(6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void expect_ev(ev_kind_e k, int lat, int iter, int stall, int terr);
    ev_t e;
    e.kind = k; e.lat = lat; e.iter = iter; e.stall = stall; e.terr = terr;
    exp_q.push_back(e);
  endfunction

  function automatic logic pulse_of(ev_kind_e k);
    case (k)
      EV_RL:   return bus.rl_start;
      EV_MU:   return bus.mu_start;
      default: return bus.done;
    endcase
  endfunction

  // Scoreboard monitor: every launch/done pulse must match the next expected event.
  always @(negedge clk) begin
    if (rst && (bus.rl_start || bus.mu_start || bus.done)) begin
      check("pulse_onehot", int'(bus.rl_start) + int'(bus.mu_start) + int'(bus.done), 1);
      mon_kind = bus.done ? EV_DONE : (bus.mu_start ? EV_MU : EV_RL);
      mon_ref  = (start_cyc > last_evt_cyc) ? start_cyc : last_evt_cyc;
      if (exp_q.size() == 0) begin
        check({"unexpected_", mon_kind.name()}, 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check({"kind_", mon_e.kind.name()}, mon_kind, mon_e.kind);
        if (mon_e.lat >= 0) check({"lat_", mon_e.kind.name()}, cyc - mon_ref, mon_e.lat);
        check({"iter_", mon_e.kind.name()}, bus.iter_cnt, mon_e.iter);
        check({"stall_", mon_e.kind.name()}, bus.stall_cnt, mon_e.stall);
        check({"terr_", mon_e.kind.name()}, bus.timeout_err, mon_e.terr);
      end
      last_evt_cyc = cyc;
    end
  end

  task automatic wait_pulse(input ev_kind_e k, input int budget);
    int n = 0;
    while (!pulse_of(k) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({"arrive_", k.name()}, pulse_of(k), 1);
  endtask

  task automatic do_start(input int n);
    bus.num_iter = 16'(n);
    bus.start    = 1'b1;
    start_cyc    = cyc;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // One RL phase: reading_done after rd_delay cycles, optional force_valid glitch in drain,
  // optional back-pressure burst, optional ignored start/mu_done poke during RL_READ.
  task automatic rl_phase(input int rd_delay, input int glitch_at, input int bp_len, input bit poke);
    wait_pulse(EV_RL, 20);
    for (int i = 1; i <= rd_delay; i++) begin
      @(negedge clk);
      bus.back_pressure = (i <= bp_len) ? BP3 : 64'h0;
      bus.start         = poke && (i == 2);
      bus.mu_done       = poke && (i == 2);
      if (poke && i == 2) bus.num_iter = 16'd7;
      if (i == rd_delay) bus.reading_done = '1;
    end
    @(negedge clk);
    bus.reading_done = '0;
    if (glitch_at > 0) begin
      repeat (glitch_at) @(negedge clk);
      bus.force_valid[17] = 1'b1;
      @(negedge clk);
      bus.force_valid = '0;
    end
    wait_pulse(EV_MU, 40);
  endtask

  task automatic run_iter(input int rd_delay, input int glitch_at, input int bp_len,
                          input int mu_delay, input bit poke);
    rl_phase(rd_delay, glitch_at, bp_len, poke);
    repeat (mu_delay) @(negedge clk);
    bus.mu_done = 1'b1;
    @(negedge clk);
    bus.mu_done = 1'b0;
  endtask

  initial begin
    int k;
    bus.start = 1'b0; bus.abort = 1'b0; bus.num_iter = '0; bus.mu_done = 1'b0;
    bus.reading_done = '0; bus.back_pressure = '0; bus.force_valid = '0;
    bus.filter_buffer_empty = '1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rl_start", bus.rl_start, 0);
    check("rst_mu_start", bus.mu_start, 0);
    check("rst_iter_cnt", bus.iter_cnt, 0);
    check("rst_stall_cnt", bus.stall_cnt, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    rst = 1'b1;
    @(negedge clk);

    // Two full iterations
    expect_ev(EV_RL, 1, 0, 0, 0);  expect_ev(EV_MU, 14, 0, 0, 0);
    expect_ev(EV_RL, 4, 1, 0, 0);  expect_ev(EV_MU, 14, 1, 0, 0);
    expect_ev(EV_DONE, 4, 2, 0, 0);
    do_start(2);
    run_iter(5, 0, 0, 3, 1'b0);
    run_iter(5, 0, 0, 3, 1'b0);
    wait_pulse(EV_DONE, 20);
    @(negedge clk);
    check("s1_busy_after_done", bus.busy, 0);
    check("s1_iter_hold", bus.iter_cnt, 2);

    // Zero iterations: straight to done, iter_cnt cleared
    expect_ev(EV_DONE, 1, 0, 0, 0);
    do_start(0);
    wait_pulse(EV_DONE, 5);
    @(negedge clk);
    check("s2_busy_after_done", bus.busy, 0);

    // Drain restarts after a force_valid glitch
    expect_ev(EV_RL, 1, 0, 0, 0);  expect_ev(EV_MU, 20, 0, 0, 0);
    expect_ev(EV_DONE, 4, 1, 0, 0);
    do_start(1);
    run_iter(5, 5, 0, 3, 1'b0);
    wait_pulse(EV_DONE, 20);
    @(negedge clk);

    // Back-pressure burst in RL_READ, plus start/mu_done pokes that must be ignored
    expect_ev(EV_RL, 1, 0, 0, 0);  expect_ev(EV_MU, 21, 0, 10, 0);
    expect_ev(EV_DONE, 4, 1, 10, 0);
    do_start(1);
    run_iter(12, 0, 10, 3, 1'b1);
    wait_pulse(EV_DONE, 20);
    @(negedge clk);
    check("s4_stall_hold", bus.stall_cnt, 10);

    // Watchdog: reading never completes
    expect_ev(EV_RL, 1, 0, 0, 0);
    do_start(1);
    wait_pulse(EV_RL, 5);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.timeout_err && k < 100);
    check("wdog_cycles", k, 64);
    repeat (5) @(negedge clk);
    check("err_busy_hold", bus.busy, 1);
    check("err_terr_hold", bus.timeout_err, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("err_abort_busy", bus.busy, 0);
    check("err_terr_sticky", bus.timeout_err, 1);
    expect_ev(EV_DONE, 1, 0, 0, 0);
    do_start(0);
    wait_pulse(EV_DONE, 5);
    @(negedge clk);

    // Abort in MU_WAIT: no done, later mu_done ignored
    expect_ev(EV_RL, 1, 0, 0, 0);  expect_ev(EV_MU, 14, 0, 0, 0);
    do_start(1);
    rl_phase(5, 0, 0, 1'b0);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    bus.mu_done = 1'b1;
    @(negedge clk);
    bus.mu_done = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_stays", bus.busy, 0);
    check("abort_iter_hold", bus.iter_cnt, 0);

    // Reset mid-run abandons the run
    expect_ev(EV_RL, 1, 0, 0, 0);
    do_start(3);
    wait_pulse(EV_RL, 5);
    bus.back_pressure = BP3;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_stall", bus.stall_cnt, 0);
    check("midrst_rl_start", bus.rl_start, 0);
    bus.back_pressure = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("postrst_busy", bus.busy, 0);
    check("postrst_iter", bus.iter_cnt, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
